// File: rtl/phase_delay_calc.sv
`timescale 1ns/1ps
// Measures the sigIn period in clk cycles and scales it by phaseIn/2^PHASE_SIZE into waitCntOut.
// Optional macro PHASE_DELAY_ROUND_EN: round-to-nearest with saturation instead of floor.
module phase_delay_calc #(
  parameter int WAIT_CNT_SIZE = 11,
  parameter int PHASE_SIZE    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     sigIn,
  input  logic [PHASE_SIZE-1:0]    phaseIn,
  output logic [WAIT_CNT_SIZE-1:0] waitCntOut,
  output logic                     waitCntValid,
  output logic                     locked,
  output logic                     periodOvf
);

  localparam int W  = WAIT_CNT_SIZE;
  localparam int P  = PHASE_SIZE;
  localparam int AW = W + P;
  localparam int BW = $clog2(P + 1);
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, CALC, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_prev_q;
  logic                   edge_q;
  logic [W-1:0]           cnt_q, cnt_d;

  state_t        state_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] mcand_q;
  logic [P-1:0]  phase_q;
  logic [BW-1:0] bit_q;
  logic [W-1:0]  wait_cnt_q, result_d;
  logic          valid_q, locked_q, ovf_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q     <= '0;
      sig_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sigIn};
      sig_prev_q <= sync_q[SYNC_STAGES-1];
      edge_q     <= sync_q[SYNC_STAGES-1] & ~sig_prev_q;
      cnt_q      <= cnt_d;
    end
  end

  // Counter reads N at a capture edge N cycles after the previous one, and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_q) begin
      cnt_d = W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_comb begin
    acc_d = acc_q + (phase_q[0] ? mcand_q : '0);
  end

`ifdef PHASE_DELAY_ROUND_EN
  localparam logic [AW:0] HALF = (AW + 1)'(1) << (P - 1);
  logic [AW:0] rnd_sum;
  always_comb begin
    rnd_sum = {1'b0, acc_q} + HALF;
    if ((rnd_sum >> P) > {{(P + 1){1'b0}}, CNT_MAX}) begin
      result_d = CNT_MAX;
    end else begin
      result_d = W'(rnd_sum >> P);
    end
  end
`else
  always_comb begin
    result_d = W'(acc_q >> P);
  end
`endif

  // A capture edge takes priority over both saturation and a pending multiply.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      wait_cnt_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      if (edge_q) begin
        if (state_q == IDLE) begin
          state_q <= ARMED;
        end else begin
          mcand_q <= AW'(cnt_q);
          phase_q <= phaseIn;
          acc_q   <= '0;
          bit_q   <= '0;
          state_q <= CALC;
        end
      end else if (cnt_q == CNT_MAX && state_q != IDLE) begin
        ovf_q    <= 1'b1;
        locked_q <= 1'b0;
        state_q  <= IDLE;
      end else if (state_q == CALC) begin
        if (bit_q != BW'(P)) begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          phase_q <= phase_q >> 1;
          bit_q   <= bit_q + BW'(1);
        end else begin
          wait_cnt_q <= result_d;
          valid_q    <= 1'b1;
          locked_q   <= 1'b1;
          state_q    <= LOCKED;
        end
      end
    end
  end

  assign waitCntOut   = wait_cnt_q;
  assign waitCntValid = valid_q;
  assign locked       = locked_q;
  assign periodOvf    = ovf_q;

endmodule

// File: tb/tb_phase_delay_calc.sv
`timescale 1ns/1ps
// Random and directed sigIn edge trains scored against a period/phase arithmetic model.
module tb_phase_delay_calc;

  localparam int W = 11;
  localparam int P = 8;
  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rstN;
  logic         sigIn;
  logic [P-1:0] phaseIn;
  logic [W-1:0] waitCntOut;
  logic         waitCntValid;
  logic         locked;
  logic         periodOvf;

  phase_delay_calc #(.WAIT_CNT_SIZE(W), .PHASE_SIZE(P), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstN(rstN), .sigIn(sigIn), .phaseIn(phaseIn),
    .waitCntOut(waitCntOut), .waitCntValid(waitCntValid),
    .locked(locked), .periodOvf(periodOvf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned t; int unsigned v; } exp_t;
  exp_t        vq[$];
  int unsigned oq[$];
  int unsigned rk[$];
  int unsigned rp[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_out = 0;
  bit          exp_locked = 0;
  bit          m_armed = 0;
  int unsigned m_prev = 0;
  bit          fresh = 1;
  int unsigned next_k = 0;

  function automatic void chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int unsigned ref_delay(int unsigned period, int unsigned ph);
    int unsigned r;
`ifdef PHASE_DELAY_ROUND_EN
    r = (period * ph + 2**(P-1)) / (2**P);
    if (r > 2**W - 1) r = 2**W - 1;
`else
    r = (period * ph) / (2**P);
`endif
    return r;
  endfunction

  // Rise k is the first posedge sampling sigIn high; its capture edge is k+3.
  task automatic add_seg(int unsigned gap, int n, int unsigned ph);
    for (int i = 0; i < n; i++) begin
      if (fresh) begin
        next_k = cyc + 5;
        fresh  = 0;
      end else begin
        next_k += gap;
      end
      rk.push_back(next_k);
      rp.push_back(ph);
    end
  endtask

  task automatic build(bit quiet, int unsigned cut);
    int unsigned c;
    for (int j = 0; j < rk.size(); j++) begin
      c = rk[j] + 3;
      if (m_armed && c - m_prev > 2047) begin
        if (m_prev + 2047 < cut) oq.push_back(m_prev + 2047);
        m_armed = 0;
      end
      if (m_armed && (j == rk.size() - 1 || rk[j+1] + 3 >= c + 10) && c + 9 < cut)
        vq.push_back('{c + 9, ref_delay(c - m_prev, rp[j])});
      m_armed = 1;
      m_prev  = c;
    end
    if (quiet && m_armed && m_prev + 2047 < cut) begin
      oq.push_back(m_prev + 2047);
      m_armed = 0;
    end
  endtask

  task automatic wait_neg(int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive();
    int unsigned gap, h;
    for (int j = 0; j < rk.size(); j++) begin
      gap = (j < rk.size() - 1) ? rk[j+1] - rk[j] : 8;
      h   = (gap / 2 < 4) ? 4 : gap / 2;
      wait_neg(rk[j] - 1);
      sigIn   = 1'b1;
      phaseIn = P'(rp[j]);
      wait_neg(rk[j] + 3);
      if (gap >= 10 && $urandom_range(1, 0) == 1) phaseIn = P'($urandom);
      wait_neg(rk[j] + h - 1);
      sigIn = 1'b0;
    end
  endtask

  task automatic run(bit quiet, int unsigned settle, int unsigned cut);
    int unsigned last;
    last = rk[rk.size() - 1] + 3;
    build(quiet, cut);
    drive();
    wait_neg(last + settle);
    rk.delete();
    rp.delete();
    if (quiet) fresh = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int unsigned t;
    if (!rstN) begin
      exp_out    = 0;
      exp_locked = 0;
    end else begin
      if (waitCntValid) begin
        chk("valid_expected", 32'(vq.size() > 0), 1);
        if (vq.size() > 0) begin
          e = vq.pop_front();
          chk("valid_cycle", cyc, e.t);
          chk("valid_value", 32'(waitCntOut), e.v);
          exp_out    = e.v;
          exp_locked = 1;
        end
      end else if (vq.size() > 0 && vq[0].t <= cyc) begin
        e = vq.pop_front();
        chk("valid_present", 32'(waitCntValid), 1);
        exp_out    = e.v;
        exp_locked = 1;
      end
      if (periodOvf) begin
        chk("ovf_expected", 32'(oq.size() > 0), 1);
        if (oq.size() > 0) begin
          t = oq.pop_front();
          chk("ovf_cycle", cyc, t);
          exp_locked = 0;
        end
      end else if (oq.size() > 0 && oq[0] <= cyc) begin
        void'(oq.pop_front());
        chk("ovf_present", 32'(periodOvf), 1);
        exp_locked = 0;
      end
      chk("out_hold", 32'(waitCntOut), exp_out);
      chk("locked", 32'(locked), 32'(exp_locked));
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned r, gap, ph;
    int n;
    rstN = 1'b1; sigIn = 1'b0; phaseIn = '0;
    #2 rstN = 1'b0;
    #1;
    chk("rst_out", 32'(waitCntOut), 0);
    chk("rst_valid", 32'(waitCntValid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ovf", 32'(periodOvf), 0);
    repeat (6) begin
      @(negedge clk);
      sigIn = ~sigIn;
    end
    chk("rst_hold_out", 32'(waitCntOut), 0);
    chk("rst_hold_valid", 32'(waitCntValid), 0);
    sigIn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);

    add_seg(100, 4, 64);  run(0, 15, NONE);
    chk("p100_ph64", 32'(waitCntOut), 25);
    chk("p100_locked", 32'(locked), 1);
    add_seg(100, 3, 255); run(0, 15, NONE);
`ifdef PHASE_DELAY_ROUND_EN
    chk("p100_ph255", 32'(waitCntOut), 100);
`else
    chk("p100_ph255", 32'(waitCntOut), 99);
`endif
    add_seg(100, 2, 0);   run(0, 15, NONE);
    chk("p100_ph0", 32'(waitCntOut), 0);
    add_seg(101, 2, 128); run(0, 15, NONE);
`ifdef PHASE_DELAY_ROUND_EN
    chk("p101_ph128", 32'(waitCntOut), 51);
`else
    chk("p101_ph128", 32'(waitCntOut), 50);
`endif
    add_seg(100, 2, 64);  add_seg(200, 2, 64); run(0, 15, NONE);
    chk("p200_ph64", 32'(waitCntOut), 50);
    add_seg(100, 1, 64);  add_seg(6, 12, 64);  run(0, 0, NONE);
    chk("p6_out_held", 32'(waitCntOut), 50);
    chk("p6_locked", 32'(locked), 1);
    wait_neg(cyc + 15);
    add_seg(100, 2, 64);  run(1, 2047 + 20, NONE);
    chk("stop_out_held", 32'(waitCntOut), 25);
    chk("stop_unlocked", 32'(locked), 0);
    add_seg(100, 2, 64);  add_seg(2047, 1, 128); add_seg(2048, 1, 64); add_seg(100, 1, 64);
    run(1, 2047 + 20, NONE);
    chk("sat_edge_out", 32'(waitCntOut), 25);
    chk("sat_edge_unlocked", 32'(locked), 0);

    for (int s = 0; s < 30; s++) begin
      r  = $urandom_range(99, 0);
      ph = $urandom_range(255, 0);
      if (r < 8) begin
        gap = $urandom_range(2055, 2040); n = 1;
      end else if (r < 25) begin
        gap = $urandom_range(12, 6); n = $urandom_range(4, 1);
      end else begin
        gap = $urandom_range(300, 10); n = $urandom_range(4, 1);
      end
      add_seg(gap, n, ph);
    end
    run(1, 2047 + 20, NONE);

    add_seg(100, 3, 64);
    run(0, 3, rk[2] + 7);
    #2 rstN = 1'b0;
    #1;
    chk("midcalc_rst_out", 32'(waitCntOut), 0);
    chk("midcalc_rst_valid", 32'(waitCntValid), 0);
    chk("midcalc_rst_locked", 32'(locked), 0);
    chk("midcalc_rst_ovf", 32'(periodOvf), 0);
    m_armed = 0;
    fresh   = 1;
    repeat (3) @(negedge clk);
    #3 rstN = 1'b1;
    @(negedge clk);
    add_seg(100, 3, 64);  run(0, 15, NONE);
    chk("after_rst_out", 32'(waitCntOut), 25);
    chk("after_rst_locked", 32'(locked), 1);

    wait_neg(cyc + 20);
    chk("valid_queue_drained", 32'(vq.size()), 0);
    chk("ovf_queue_drained", 32'(oq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_delay_calc.md
Name: phase_delay_calc

Overview:
- Upstream feeder for the rising-edge delay stage.
- Measures the period of the reference signal sigIn in clk cycles.
- Scales the period by a programmable phase fraction and produces the waitCnt word the delay stage consumes.
- Lets the board hold a fixed phase, not a fixed time, as the input frequency drifts.

Parameters:
WAIT_CNT_SIZE, 11, width of period counter and waitCntOut (matches delay stage)
PHASE_SIZE, 8, width of phase word; phase fraction = phaseIn / 2^PHASE_SIZE
SYNC_STAGES, 2, synchronizer flops on sigIn (minimum 2)

Ports:
clk  input  1  system clock
rstN  input  1  asynchronous active-low reset
sigIn  input  1  asynchronous reference signal
phaseIn  input  PHASE_SIZE  requested phase fraction
waitCntOut  output  WAIT_CNT_SIZE  delay in clk cycles, to delay stage waitCnt
waitCntValid  output  1  one-cycle pulse when waitCntOut updates
locked  output  1  high while a valid period measurement is held
periodOvf  output  1  one-cycle pulse when the period counter saturates

Behaviour:
- Interface: one clock (clk); reset rstN is asynchronous and active-low. All state clears immediately when rstN falls. Normal operation resumes on the first clk edge after rstN rises.
- Reset values: waitCntOut=0, waitCntValid=0, locked=0, periodOvf=0, state=IDLE, synchronizer flops=0.
- Synchronizer: sigIn passes through SYNC_STAGES flops. A registered rising-edge detect follows. The capture edge occurs SYNC_STAGES+1 clk edges after the first clk edge that samples sigIn high.
- Period counter (periodCnt, WAIT_CNT_SIZE bits):
  - Loaded to 1 on every capture edge; increments by 1 each other cycle.
  - Saturates at 2^WAIT_CNT_SIZE-1 and never wraps.
  - With capture edges N cycles apart, the value captured is N.
- States:
  - IDLE: no edge seen. On first capture edge -> ARMED, counter loaded. No calculation started.
  - ARMED: on next capture edge, latch period=periodCnt, latch phaseIn, start multiply -> CALC.
  - CALC: shift-add multiply, one bit of phase per cycle, PHASE_SIZE cycles, with a product accumulator of WAIT_CNT_SIZE+PHASE_SIZE bits. On completion:
    - waitCntOut = product >> PHASE_SIZE (floor).
    - waitCntValid pulses for 1 cycle.
    - locked=1.
    - -> LOCKED.
    - Total latency from capture edge to waitCntOut update: PHASE_SIZE+1 clk edges.
  - LOCKED: on each capture edge, latch period and phaseIn -> CALC. waitCntOut holds its last value during CALC and locked stays 1.
- Edge during CALC: abort the current multiply, latch the new period and phaseIn, restart CALC. waitCntOut is not updated by the aborted calculation.
  - Consequence: if the period is shorter than PHASE_SIZE+2 cycles, waitCntOut never updates. This is accepted.
- Saturation: when periodCnt reaches all-ones in ARMED, CALC or LOCKED:
  - periodOvf pulses once.
  - locked -> 0, state -> IDLE, any CALC is aborted.
  - waitCntOut holds its value.
- Edge coincident with saturation: the edge wins. Counter reloads, no periodOvf pulse.
- phaseIn changes mid-CALC are ignored until the next capture edge.
- phaseIn=0 produces waitCntOut=0. The maximum result is always < period, so no output overflow.

Optional Feature:
- Macro: PHASE_DELAY_ROUND_EN.
- Defined: at completion add 2^(PHASE_SIZE-1) before the shift, giving round-to-nearest. Saturate the result at 2^WAIT_CNT_SIZE-1.
- Undefined: truncating floor as above. No rounding adder is synthesized.

Test Plan:
- Reset, then sigIn square wave with period 100 clk, phaseIn=64 -> no output after 1st edge; after 2nd edge, waitCntValid pulses 9 cycles after the capture edge with waitCntOut=25; locked=1.
- Period 100, phaseIn=255 -> waitCntOut=99 (PHASE_DELAY_ROUND_EN: 100). phaseIn=0 -> 0. phaseIn=128, period 101 -> 50 (rounded: 51).
- Locked at period 100, then stop sigIn -> periodOvf pulses exactly once ~2047 cycles after the last edge; locked=0; waitCntOut stays 25; restart needs 2 edges.
- Change period 100 -> 200 mid-stream with phaseIn=64 -> waitCntOut steps 25 -> 50 one measurement later, with no intermediate value.
- Period 6 clk (< PHASE_SIZE+2) after lock -> every CALC aborts, waitCntValid never pulses, waitCntOut unchanged, locked stays 1.
- Assert rstN low mid-CALC, asynchronous to clk -> all outputs 0 immediately; after release, behaviour identical to a fresh start (2 edges needed).
